// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit controller: FSM states, TX mux
// select encodings and parity type constants.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [2:0] MUX_START = 3'b000;
  localparam logic [2:0] MUX_DATA  = 3'b001;
  localparam logic [2:0] MUX_PAR   = 3'b010;
  localparam logic [2:0] MUX_STOP  = 3'b011;
  localparam logic [2:0] MUX_IDLE  = 3'b101;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic [2:0] mux_decode(input state_t s);
    logic [2:0] sel;
    sel = MUX_IDLE;
    case (s)
      ST_START:  sel = MUX_START;
      ST_DATA:   sel = MUX_DATA;
      ST_PARITY: sel = MUX_PAR;
      ST_STOP:   sel = MUX_STOP;
      default:   sel = MUX_IDLE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload latch and LSB-first bit selector for the UART transmitter.
// ser_data follows the indexed bit while shifting and holds the last one otherwise.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] p_data,
  output logic                  ser_data,
  output logic                  last_bit
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] data_q;
  logic [CW-1:0]         cnt;
  logic                  hold_q;

  assign last_bit = (cnt == CW'(DATA_WIDTH - 1));
  assign ser_data = shift_en ? data_q[cnt] : hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      cnt    <= '0;
      hold_q <= 1'b0;
    end else begin
      if (load) begin
        data_q <= p_data;
      end
      if (shift_en) begin
        hold_q <= data_q[cnt];
        cnt    <= last_bit ? '0 : cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frame FSM, parity and busy generation, with the
// payload serializer as a sub-block. mux_sel is decoded from the state register only.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [2:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  state_t state, state_next;
  logic   par_en_q;
  logic   accept;
  logic   shift_en;
  logic   last_bit;

  assign accept   = Data_Valid && ((state == ST_IDLE) || (state == ST_STOP));
  assign shift_en = (state == ST_DATA);
  assign mux_sel  = mux_decode(state);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   state_next = accept ? ST_START : ST_IDLE;
      ST_START:  state_next = ST_DATA;
      ST_DATA:   if (last_bit) state_next = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: state_next = ST_STOP;
      ST_STOP:   state_next = accept ? ST_START : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Parity is taken from the same P_DATA word the serializer latches, so it
  // equals the reduction of the latched payload for the whole frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ST_START) || (state_next == ST_DATA) ||
               (state_next == ST_PARITY);
      if (accept) begin
        par_en_q <= PAR_EN;
        par_bit  <= (^P_DATA) ^ (PAR_TYP == PAR_ODD);
      end
    end
  end

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .clk      (CLK),
    .rst      (RST),
    .load     (accept),
    .shift_en (shift_en),
    .p_data   (P_DATA),
    .ser_data (ser_data),
    .last_bit (last_bit)
  );

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl (DATA_WIDTH = 8).
module tb_uart_tx_ctrl;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [2:0] mux_sel;
  logic       ser_data;
  logic       par_bit;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .mux_sel    (mux_sel),
    .ser_data   (ser_data),
    .par_bit    (par_bit),
    .busy       (busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic accept_req(input logic [7:0] d, input logic pe, input logic pt);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
  endtask

  // Walks one frame starting in its START cycle. dv_mode: 0 = no request,
  // 1 = one-cycle request in DATA bit 2 (must be ignored), 2 = request held
  // through STOP (back-to-back). alt_data is driven on P_DATA during DATA.
  task automatic walk_frame(input string tag, input logic [7:0] exp_bits, input logic pe,
                            input logic exp_par, input int exp_len, input int dv_mode,
                            input logic [7:0] alt_data);
    int len;
    int busy_cnt;
    len = 0;
    busy_cnt = 0;
    Data_Valid = (dv_mode == 2);
    check_eq({tag, ".start_mux"}, 32'(mux_sel), 32'(3'b000));
    if (mux_sel != 3'b101) len++;
    if (busy) busy_cnt++;
    tick();
    for (int i = 0; i < 8; i++) begin
      P_DATA     = alt_data;
      Data_Valid = (dv_mode == 2) || (dv_mode == 1 && i == 2);
      if (dv_mode == 1) begin
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b1;
      end
      check_eq($sformatf("%s.data_mux%0d", tag, i), 32'(mux_sel), 32'(3'b001));
      check_eq($sformatf("%s.bit%0d", tag, i), 32'(ser_data), 32'(exp_bits[i]));
      if (i == 0) check_eq({tag, ".par_early"}, 32'(par_bit), 32'(exp_par));
      if (mux_sel != 3'b101) len++;
      if (busy) busy_cnt++;
      tick();
    end
    if (pe) begin
      check_eq({tag, ".par_mux"}, 32'(mux_sel), 32'(3'b010));
      check_eq({tag, ".par_bit"}, 32'(par_bit), 32'(exp_par));
      if (mux_sel != 3'b101) len++;
      if (busy) busy_cnt++;
      tick();
    end
    check_eq({tag, ".stop_mux"}, 32'(mux_sel), 32'(3'b011));
    check_eq({tag, ".stop_busy"}, 32'(busy), 32'(0));
    if (mux_sel != 3'b101) len++;
    if (busy) busy_cnt++;
    tick();
    check_eq({tag, ".len"}, 32'(len), 32'(exp_len));
    check_eq({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(exp_len - 1));
    if (dv_mode == 2) check_eq({tag, ".b2b_start"}, 32'(mux_sel), 32'(3'b000));
    else              check_eq({tag, ".after_mux"}, 32'(mux_sel), 32'(3'b101));
    PAR_EN = pe;
  endtask

  initial begin
    RST = 1'b1;
    P_DATA = 8'h00;
    Data_Valid = 1'b1;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    tick();
    tick();
    check_eq("rst.mux", 32'(mux_sel), 32'(3'b101));
    check_eq("rst.busy", 32'(busy), 32'(0));
    check_eq("rst.ser", 32'(ser_data), 32'(0));
    check_eq("rst.par", 32'(par_bit), 32'(0));
    RST = 1'b0;
    Data_Valid = 1'b0;
    tick();
    check_eq("idle.mux", 32'(mux_sel), 32'(3'b101));

    // 0xA5: four ones -> even parity 0, odd parity 1
    accept_req(8'hA5, 1'b1, 1'b0);
    walk_frame("even_a5", 8'hA5, 1'b1, 1'b0, 11, 0, 8'hA5);
    accept_req(8'hA5, 1'b1, 1'b1);
    walk_frame("odd_a5", 8'hA5, 1'b1, 1'b1, 11, 0, 8'hA5);
    accept_req(8'h3C, 1'b0, 1'b0);
    walk_frame("nopar_3c", 8'h3C, 1'b0, 1'b0, 10, 0, 8'h3C);

    // Back-to-back: 0x01 then 0x80, each with a single one -> even parity 1
    accept_req(8'h01, 1'b1, 1'b0);
    walk_frame("b2b_01", 8'h01, 1'b1, 1'b1, 11, 2, 8'h80);
    walk_frame("b2b_80", 8'h80, 1'b1, 1'b1, 11, 0, 8'h80);

    // Request and input changes during DATA must not disturb the 0x55 frame
    accept_req(8'h55, 1'b1, 1'b0);
    walk_frame("stable_55", 8'h55, 1'b1, 1'b0, 11, 1, 8'hFF);
    tick();
    check_eq("stable.no_extra", 32'(mux_sel), 32'(3'b101));

    // Mid-frame reset in the 4th DATA cycle; 0x55 odd parity -> par_bit 1 before reset
    accept_req(8'h55, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    check_eq("mid.pre_mux", 32'(mux_sel), 32'(3'b001));
    check_eq("mid.pre_par", 32'(par_bit), 32'(1));
    RST = 1'b1;
    Data_Valid = 1'b1;
    tick();
    check_eq("mid.rst_mux", 32'(mux_sel), 32'(3'b101));
    check_eq("mid.rst_busy", 32'(busy), 32'(0));
    check_eq("mid.rst_par", 32'(par_bit), 32'(0));
    check_eq("mid.rst_ser", 32'(ser_data), 32'(0));
    RST = 1'b0;
    accept_req(8'hA5, 1'b1, 1'b0);
    walk_frame("after_rst", 8'hA5, 1'b1, 1'b0, 11, 0, 8'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
